cnt_threshold_monitor: RTL and testbench

- Downstream consumer of the 8-entry counter array.
- Samples the `cnt` bus every cycle and classifies each counter as LOW, NORMAL or HIGH against programmable thresholds.
- Queues one pending region-change event per counter and reports events one at a time to a status/interrupt collector over a valid/ready handshake, using round-robin fairness.

---
 rtl/cnt_threshold_monitor.sv | 143 ++++++++++++++
 tb/tb_cnt_threshold_monitor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_threshold_monitor.sv
// Classifies each counter against lo/hi thresholds, queues one region-change event per
// counter and reports pending events round-robin over a valid/ready handshake.
// state   | meaning
// IDLE    | no event presented
// PRESENT | evt_* valid, waiting for evt_ready
module cnt_threshold_monitor #(
  parameter int NUM_CNT = 8,
  parameter int CNT_W   = 5,
  parameter int ADDR_W  = 3,
  parameter int DROP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cnt [0:NUM_CNT-1],
  input  logic              en,
  input  logic [CNT_W-1:0]  hi_thresh,
  input  logic [CNT_W-1:0]  lo_thresh,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ADDR_W-1:0] evt_addr,
  output logic [1:0]        evt_type,
  output logic [CNT_W-1:0]  evt_value,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              cfg_err
);

  localparam logic [1:0] RG_NORM = 2'b00;
  localparam logic [1:0] RG_HIGH = 2'b01;
  localparam logic [1:0] RG_LOW  = 2'b10;

  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_nxt;

  logic [1:0]        region    [NUM_CNT];
  logic [1:0]        cls       [NUM_CNT];
  logic [1:0]        slot_type [NUM_CNT];
  logic [CNT_W-1:0]  slot_val  [NUM_CNT];
  logic [NUM_CNT-1:0] slot_full, cap, drop;
  logic [ADDR_W-1:0] rr_ptr, base, sel_idx;
  logic              sel_found, load, evt_clear, primed;
  logic [DROP_W:0]   drop_sum;
  logic [DROP_W-1:0] drop_nxt;

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      if (cnt[i] >= hi_thresh)      cls[i] = RG_HIGH;
      else if (cnt[i] <= lo_thresh) cls[i] = RG_LOW;
      else                          cls[i] = RG_NORM;
      cap[i] = en && primed && !cfg_err && (cls[i] != RG_NORM) && (cls[i] != region[i]);
    end
  end

  // While presenting, evt_addr becomes rr_ptr on handshake, so search from it directly
  always_comb begin
    base      = (state == PRESENT) ? evt_addr : rr_ptr;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= NUM_CNT; k++) begin
      if (!sel_found && slot_full[(int'(base) + k) % NUM_CNT]) begin
        sel_found = 1'b1;
        sel_idx   = ADDR_W'((int'(base) + k) % NUM_CNT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = PRESENT;
      PRESENT: if (evt_ready && !sel_found) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load      = sel_found && ((state == IDLE) || evt_ready);
    evt_clear = (state == PRESENT) && evt_ready && !sel_found;
  end

  // A slot being unloaded this cycle is free for a new capture without a drop
  always_comb begin
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < NUM_CNT; i++) begin
      drop[i]  = cap[i] && slot_full[i] && !(load && (sel_idx == ADDR_W'(i)));
      drop_sum = drop_sum + (DROP_W+1)'(drop[i]);
    end
    drop_nxt = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed    <= 1'b0;
      slot_full <= '0;
      drop_cnt  <= '0;
      cfg_err   <= 1'b0;
      for (int i = 0; i < NUM_CNT; i++) begin
        region[i]    <= RG_NORM;
        slot_type[i] <= 2'b00;
        slot_val[i]  <= '0;
      end
    end else begin
      primed   <= en;
      cfg_err  <= (lo_thresh >= hi_thresh);
      drop_cnt <= drop_nxt;
      for (int i = 0; i < NUM_CNT; i++) begin
        if (en) region[i] <= cls[i];
        if (cap[i]) begin
          slot_full[i] <= 1'b1;
          slot_type[i] <= cls[i];
          slot_val[i]  <= cnt[i];
        end else if (load && (sel_idx == ADDR_W'(i))) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_addr  <= '0;
      evt_type  <= 2'b00;
      evt_value <= '0;
      rr_ptr    <= ADDR_W'(NUM_CNT - 1);
    end else begin
      if ((state == PRESENT) && evt_ready) rr_ptr <= evt_addr;
      if (load) begin
        evt_valid <= 1'b1;
        evt_addr  <= sel_idx;
        evt_type  <= slot_type[sel_idx];
        evt_value <= slot_val[sel_idx];
      end else if (evt_clear) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cnt_threshold_monitor.sv
// Directed bench for cnt_threshold_monitor: expected events are queued by the stimulus
// and checked by an independent monitor at every handshake.
module tb_cnt_threshold_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] cnt [0:7];
  logic       en, evt_ready, evt_valid, cfg_err;
  logic [4:0] hi_thresh, lo_thresh, evt_value;
  logic [2:0] evt_addr;
  logic [1:0] evt_type;
  logic [7:0] drop_cnt;

  typedef struct packed {
    logic [2:0] a;
    logic [1:0] t;
    logic [4:0] v;
  } evt_t;

  evt_t exp_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  cnt_threshold_monitor dut (
    .clk(clk), .rst_n(rst_n), .cnt(cnt), .en(en),
    .hi_thresh(hi_thresh), .lo_thresh(lo_thresh),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_addr(evt_addr),
    .evt_type(evt_type), .evt_value(evt_value), .drop_cnt(drop_cnt), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_evt(input int a, input int t, input int v);
    evt_t e;
    e.a = 3'(a); e.t = 2'(t); e.v = 5'(v);
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || evt_valid) && n < 100) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (2) tick();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, int'(evt_valid), 0);
    check({name, "_addr"},  int'(evt_addr), 0);
    check({name, "_type"},  int'(evt_type), 0);
    check({name, "_value"}, int'(evt_value), 0);
    check({name, "_drop"},  int'(drop_cnt), 0);
    check({name, "_cfg"},   int'(cfg_err), 0);
  endtask

  // Monitor: pops on every handshake and checks hold stability during stalls
  initial begin
    evt_t       e;
    logic       ps;
    logic [2:0] pa;
    logic [1:0] pt;
    logic [4:0] pv;
    ps = 1'b0; pa = '0; pt = '0; pv = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ps = 1'b0;
      end else begin
        if (ps) begin
          n_vec++;
          if (!evt_valid || evt_addr !== pa || evt_type !== pt || evt_value !== pv) begin
            n_err++;
            $display("FAIL stall_hold: got v=%0b a=%0d t=%0d val=%0d expected v=1 a=%0d t=%0d val=%0d",
                     evt_valid, evt_addr, evt_type, evt_value, pa, pt, pv);
          end
        end
        if (evt_valid && evt_ready) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_evt: got a=%0d t=%0d val=%0d expected none",
                     evt_addr, evt_type, evt_value);
          end else begin
            e = exp_q.pop_front();
            if (evt_addr !== e.a || evt_type !== e.t || evt_value !== e.v) begin
              n_err++;
              $display("FAIL evt: got a=%0d t=%0d val=%0d expected a=%0d t=%0d val=%0d",
                       evt_addr, evt_type, evt_value, e.a, e.t, e.v);
            end
          end
        end
        ps = evt_valid && !evt_ready;
        pa = evt_addr; pt = evt_type; pv = evt_value;
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; evt_ready = 1'b0;
    lo_thresh = 5'd2; hi_thresh = 5'd20;
    for (int i = 0; i < 8; i++) cnt[i] = 5'd0;
    repeat (2) tick();
    check_reset_outputs("reset");

    // priming with all counters LOW, then cnt[3] rises to HIGH
    rst_n = 1'b1; en = 1'b1; evt_ready = 1'b1;
    repeat (3) tick();
    check("prime_no_evt", int'(evt_valid), 0);
    cnt[3] = 5'd10; tick();
    expect_evt(3, 1, 20);
    cnt[3] = 5'd20; tick();
    check("latency_early", int'(evt_valid), 0);
    tick();
    check("latency_valid", int'(evt_valid), 1);
    wait_drain("drain_hi");

    // cnt[5] goes HIGH, then wraps 31->0 as a single LOW event
    expect_evt(5, 1, 31);
    cnt[5] = 5'd31; tick();
    wait_drain("drain_c5_hi");
    expect_evt(5, 2, 0);
    cnt[5] = 5'd0; tick();
    wait_drain("drain_wrap");

    // fresh reset, all NORMAL: simultaneous crossings report back-to-back
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) cnt[i] = 5'd10;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    expect_evt(1, 1, 25); expect_evt(6, 1, 25); expect_evt(7, 1, 25);
    cnt[1] = 5'd25; cnt[6] = 5'd25; cnt[7] = 5'd25;
    tick();
    tick(); check("b2b_0", int'(evt_valid), 1);
    tick(); check("b2b_1", int'(evt_valid), 1);
    tick(); check("b2b_2", int'(evt_valid), 1);
    tick(); check("b2b_end", int'(evt_valid), 0);
    wait_drain("drain_b2b");

    // bring rr_ptr to 6, then 1 and 7 together report as 7, 1
    cnt[1] = 5'd10; cnt[6] = 5'd10; cnt[7] = 5'd10; tick();
    expect_evt(6, 1, 25);
    cnt[6] = 5'd25; tick();
    wait_drain("drain_rr6");
    expect_evt(7, 1, 25); expect_evt(1, 1, 25);
    cnt[1] = 5'd25; cnt[7] = 5'd25; tick();
    wait_drain("drain_rr");

    // stall with slot 2 overwritten repeatedly
    evt_ready = 1'b0;
    expect_evt(0, 1, 25);
    cnt[0] = 5'd25; tick(); tick();
    check("stall_valid", int'(evt_valid), 1);
    cnt[2] = 5'd25; tick();
    cnt[2] = 5'd10; tick();
    cnt[2] = 5'd0;  tick();
    check("drop_1", int'(drop_cnt), 1);
    cnt[2] = 5'd10; tick();
    cnt[2] = 5'd21; tick();
    check("drop_2", int'(drop_cnt), 2);
    for (int k = 0; k < 300; k++) begin
      cnt[2] = (k % 2 == 0) ? 5'd0 : 5'd25;
      tick();
    end
    check("drop_sat", int'(drop_cnt), 255);
    expect_evt(2, 1, 25);
    evt_ready = 1'b1;
    wait_drain("drain_stall");

    // inverted thresholds: cfg_err blocks captures
    en = 1'b0; lo_thresh = 5'd20; hi_thresh = 5'd10;
    check("cfg_err_pre", int'(cfg_err), 0);
    tick();
    check("cfg_err_set", int'(cfg_err), 1);
    en = 1'b1; tick();
    cnt[3] = 5'd5;  tick();
    cnt[3] = 5'd15; tick();
    repeat (3) tick();
    check("cfg_no_evt", int'(evt_valid), 0);
    lo_thresh = 5'd2; hi_thresh = 5'd20; tick();
    check("cfg_err_clr", int'(cfg_err), 0);
    expect_evt(3, 1, 25);
    cnt[3] = 5'd25; tick();
    wait_drain("drain_cfg");

    // reset while presenting with three slots pending
    evt_ready = 1'b0;
    cnt[4] = 5'd25; cnt[5] = 5'd25; cnt[3] = 5'd0; cnt[0] = 5'd0;
    tick(); tick();
    check("pend_valid", int'(evt_valid), 1);
    rst_n = 1'b0; #1;
    check_reset_outputs("midrst");
    repeat (2) tick();
    rst_n = 1'b1; evt_ready = 1'b1;
    repeat (6) tick();
    check("no_stale", int'(evt_valid), 0);

    // enable toggled mid-crossing re-primes without an event
    en = 1'b0; cnt[3] = 5'd25; tick(); tick();
    en = 1'b1; tick();
    repeat (4) tick();
    check("reprime_no_evt", int'(evt_valid), 0);
    expect_evt(3, 2, 0);
    cnt[3] = 5'd0; tick();
    wait_drain("drain_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
